// File: rtl/alu_arbiter.sv
// ============================================================================
// Module      : alu_arbiter
// Description : Round-robin sharing of one combinational ALU between two
//               requesters, with a registered issue stage and a valid/ready
//               result return channel.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arbiter #(
    parameter int WIDTH       = 32,
    parameter int CTL_W       = 7,
    parameter int EXEC_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_A,
    input  logic [WIDTH-1:0] req0_B,
    input  logic [CTL_W-1:0] req0_ctl,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_A,
    input  logic [WIDTH-1:0] req1_B,
    input  logic [CTL_W-1:0] req1_ctl,
    output logic [WIDTH-1:0] alu_A,
    output logic [WIDTH-1:0] alu_B,
    output logic [CTL_W-1:0] alu_ctl,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_branch,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_branch,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] C_CNT_INIT = 4'(EXEC_CYCLES - 1);

    state_t           state_q,      state_d;
    logic [3:0]       cnt_q,        cnt_d;
    logic             last_grant_q, last_grant_d;
    logic [WIDTH-1:0] alu_a_q,      alu_a_d;
    logic [WIDTH-1:0] alu_b_q,      alu_b_d;
    logic [CTL_W-1:0] alu_ctl_q,    alu_ctl_d;
    logic             rsp_valid_q,  rsp_valid_d;
    logic             rsp_id_q,     rsp_id_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_branch_q, rsp_branch_d;

    logic             gnt_valid;
    logic             gnt_id;

    // Under contention the port that did not win last time is preferred.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = 1'b0;
        if (req0_valid && req1_valid) begin
            gnt_valid = 1'b1;
            gnt_id    = ~last_grant_q;
        end else if (req0_valid) begin
            gnt_valid = 1'b1;
            gnt_id    = 1'b0;
        end else if (req1_valid) begin
            gnt_valid = 1'b1;
            gnt_id    = 1'b1;
        end
    end

    assign req0_ready = (state_q == S_IDLE) && gnt_valid && !gnt_id;
    assign req1_ready = (state_q == S_IDLE) && gnt_valid &&  gnt_id;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_ctl_d    = alu_ctl_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_branch_d = rsp_branch_q;

        case (state_q)
            S_IDLE: begin
                // A grant always coincides with a transfer: grant implies valid.
                if (gnt_valid) begin
                    alu_a_d      = gnt_id ? req1_A   : req0_A;
                    alu_b_d      = gnt_id ? req1_B   : req0_B;
                    alu_ctl_d    = gnt_id ? req1_ctl : req0_ctl;
                    rsp_id_d     = gnt_id;
                    last_grant_d = gnt_id;
                    cnt_d        = C_CNT_INIT;
                    state_d      = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rsp_result_d = alu_out;
                    rsp_branch_d = alu_branch;
                    rsp_valid_d  = 1'b1;
                    state_d      = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            last_grant_q <= 1'b1;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_ctl_q    <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_branch_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_ctl_q    <= alu_ctl_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_branch_q <= rsp_branch_d;
        end
    end

    assign alu_A      = alu_a_q;
    assign alu_B      = alu_b_q;
    assign alu_ctl    = alu_ctl_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_branch = rsp_branch_q;
    assign busy       = (state_q != S_IDLE);

    // The settle counter is 4 bits wide, so only 1..15 is meaningful.
    if (EXEC_CYCLES < 1 || EXEC_CYCLES > 15) begin : g_exec_range_chk
        always_ff @(posedge clk) begin
            assert (1'b0) else $error("alu_arbiter: EXEC_CYCLES=%0d outside 1..15", EXEC_CYCLES);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Self-checking bench: transaction-level reference model plus
//               directed scenarios with hand-computed results.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_arbiter;

    localparam int W  = 32;
    localparam int CW = 7;
    localparam int E  = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          v0 = 1'b0, v1 = 1'b0, rr = 1'b0;
    logic          v0b = 1'b0, v1b = 1'b0, rrb = 1'b0;
    logic [W-1:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [CW-1:0] c0 = '0, c1 = '0;

    logic          r0, r1, rv, rid, rbr, busy;
    logic [W-1:0]  alu_a, alu_b, alu_o, rres;
    logic [CW-1:0] alu_c;
    logic          alu_br;

    logic          r0b, r1b, rvb, ridb, rbrb, busyb;
    logic [W-1:0]  alu_ab, alu_bb, alu_ob, rresb;
    logic [CW-1:0] alu_cb;
    logic          alu_brb;

    int n_cmp = 0;
    int n_err = 0;
    int tcyc  = 0;
    logic chk_en = 1'b0;

    function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [CW-1:0] c);
        case (c)
            7'd0:    return a & b;
            7'd1:    return a | b;
            7'd2:    return a + b;
            7'd6:    return a - b;
            default: return '0;
        endcase
    endfunction

    assign alu_o   = alu_f(alu_a, alu_b, alu_c);
    assign alu_br  = (alu_a == alu_b);
    assign alu_ob  = alu_f(alu_ab, alu_bb, alu_cb);
    assign alu_brb = (alu_ab == alu_bb);

    alu_arbiter #(.WIDTH(W), .CTL_W(CW), .EXEC_CYCLES(E)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v0), .req0_ready(r0), .req0_A(a0), .req0_B(b0), .req0_ctl(c0),
        .req1_valid(v1), .req1_ready(r1), .req1_A(a1), .req1_B(b1), .req1_ctl(c1),
        .alu_A(alu_a), .alu_B(alu_b), .alu_ctl(alu_c), .alu_out(alu_o), .alu_branch(alu_br),
        .rsp_valid(rv), .rsp_ready(rr), .rsp_id(rid), .rsp_result(rres), .rsp_branch(rbr),
        .busy(busy)
    );

    alu_arbiter #(.WIDTH(W), .CTL_W(CW), .EXEC_CYCLES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v0b), .req0_ready(r0b), .req0_A(a0), .req0_B(b0), .req0_ctl(c0),
        .req1_valid(v1b), .req1_ready(r1b), .req1_A(a1), .req1_B(b1), .req1_ctl(c1),
        .alu_A(alu_ab), .alu_B(alu_bb), .alu_ctl(alu_cb), .alu_out(alu_ob), .alu_branch(alu_brb),
        .rsp_valid(rvb), .rsp_ready(rrb), .rsp_id(ridb), .rsp_result(rresb), .rsp_branch(rbrb),
        .busy(busyb)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding op, tracked by the cycle it was accepted.
    int            cyc     = 0;
    logic          m_have  = 1'b0;
    int            m_txfer = 0;
    logic          m_last  = 1'b1;
    logic          m_id    = 1'b0;
    logic [W-1:0]  m_a     = '0, m_b = '0;
    logic [CW-1:0] m_c     = '0;
    int            m_g;

    function automatic int gnt(input logic x0, input logic x1, input logic last);
        if (x0 && x1) return last ? 0 : 1;
        if (x0) return 0;
        if (x1) return 1;
        return -1;
    endfunction

    assign m_g = gnt(v0, v1, m_last);

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_have <= 1'b0;
            m_last <= 1'b1;
            m_id   <= 1'b0;
            m_a    <= '0;
            m_b    <= '0;
            m_c    <= '0;
        end else if (!m_have) begin
            if (m_g >= 0) begin
                m_have  <= 1'b1;
                m_txfer <= cyc + 1;
                m_id    <= (m_g == 1);
                m_last  <= (m_g == 1);
                m_a     <= (m_g == 1) ? a1 : a0;
                m_b     <= (m_g == 1) ? b1 : b0;
                m_c     <= (m_g == 1) ? c1 : c0;
            end
        end else if ((cyc >= m_txfer + E) && rr) begin
            m_have <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("mdl_busy",   busy, m_have);
            check("mdl_ready0", r0, !m_have && (m_g == 0));
            check("mdl_ready1", r1, !m_have && (m_g == 1));
            check("mdl_rsp_valid", rv, m_have && (cyc >= m_txfer + E));
            check("mdl_alu_A",   alu_a, m_a);
            check("mdl_alu_B",   alu_b, m_b);
            check("mdl_alu_ctl", alu_c, m_c);
            if (m_have && (cyc >= m_txfer + E)) begin
                check("mdl_rsp_id",     rid, m_id);
                check("mdl_rsp_result", rres, alu_f(m_a, m_b, m_c));
                check("mdl_rsp_branch", rbr, m_a == m_b);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        tcyc++;
    endtask

    task automatic do_reset();
        v0 = 0; v1 = 0; v0b = 0; v1b = 0;
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
        tick();
    endtask

    initial begin
        int gr[$];
        int t1[$];

        // Reset values
        tick();
        chk_en = 1'b1;
        tick();
        check("rst_alu_A", alu_a, 0);
        check("rst_alu_ctl", alu_c, 0);
        check("rst_rsp_valid", rv, 0);
        check("rst_rsp_result", rres, 0);
        check("rst_rsp_id", rid, 0);
        check("rst_busy", busy, 0);
        rst_n = 1;
        tick();

        // Single op on port 0
        a0 = 32'h0F; b0 = 32'h55; c0 = 0; v0 = 1; rr = 1;
        #1;
        check("s1_ready0", r0, 1);
        check("s1_ready1", r1, 0);
        tick();
        v0 = 0;
        check("s1_exec_rsp_valid", rv, 0);
        check("s1_alu_A", alu_a, 32'h0F);
        tick();
        check("s1_rsp_valid", rv, 1);
        check("s1_rsp_result", rres, 32'h05);
        check("s1_rsp_id", rid, 0);
        check("s1_rsp_branch", rbr, 0);
        tick();
        check("s1_idle", busy, 0);

        // Contention after reset: port 0 first, then port 1
        do_reset();
        a0 = 10000; b0 = 111; c0 = 2;
        a1 = 10000; b1 = 111; c1 = 6;
        v0 = 1; v1 = 1;
        #1;
        check("s2_ready0", r0, 1);
        check("s2_ready1", r1, 0);
        tick();
        v0 = 0;
        tick();
        check("s2_rsp0_id", rid, 0);
        check("s2_rsp0_result", rres, 10111);
        tick();
        check("s2_ready1_after", r1, 1);
        tick();
        v1 = 0;
        tick();
        check("s2_rsp1_valid", rv, 1);
        check("s2_rsp1_id", rid, 1);
        check("s2_rsp1_result", rres, 9889);
        tick();

        // Sustained contention, then port 1 alone
        do_reset();
        a0 = 5; b0 = 3; c0 = 1; a1 = 9; b1 = 9; c1 = 0;
        v0 = 1; v1 = 1; rr = 1;
        #1;
        for (int i = 0; i < 60 && gr.size() < 6; i++) begin
            if (r0 && v0) gr.push_back(0);
            else if (r1 && v1) gr.push_back(1);
            tick();
        end
        check("s3_grant_count", gr.size(), 6);
        for (int i = 0; i < gr.size(); i++) check("s3_grant_order", gr[i], i % 2);
        v0 = 0;
        #1;
        for (int i = 0; i < 60 && t1.size() < 3; i++) begin
            if (r1 && v1) t1.push_back(tcyc);
            tick();
        end
        check("s3_p1_count", t1.size(), 3);
        if (t1.size() == 3) begin
            check("s3_p1_spacing_a", t1[1] - t1[0], 3);
            check("s3_p1_spacing_b", t1[2] - t1[1], 3);
        end
        v1 = 0;
        repeat (4) tick();

        // Backpressure on the response channel
        do_reset();
        rr = 0;
        a0 = 7; b0 = 7; c0 = 1; v0 = 1;
        tick();
        v0 = 0;
        a1 = 32'h100; b1 = 32'h011; c1 = 2; v1 = 1;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("s4_rsp_valid", rv, 1);
            check("s4_rsp_result", rres, 7);
            check("s4_rsp_id", rid, 0);
            check("s4_rsp_branch", rbr, 1);
            check("s4_busy", busy, 1);
            check("s4_ready0", r0, 0);
            check("s4_ready1", r1, 0);
            tick();
        end
        rr = 1;
        tick();
        check("s4_released_busy", busy, 0);
        check("s4_released_valid", rv, 0);
        check("s4_released_ready1", r1, 1);
        tick();
        v1 = 0;
        tick();
        check("s4_p1_result", rres, 32'h111);
        repeat (3) tick();

        // EXEC_CYCLES=4 instance
        a0 = 32'h1234; b0 = 32'h1234; c0 = 6; v0b = 1; rrb = 1;
        #1;
        check("s5_ready0", r0b, 1);
        tick();
        v0b = 0;
        check("s5_exec_valid", rvb, 0);
        check("s5_alu_A", alu_ab, 32'h1234);
        for (int i = 1; i < 4; i++) begin
            tick();
            check("s5_exec_valid", rvb, 0);
            check("s5_alu_A", alu_ab, 32'h1234);
            check("s5_alu_B", alu_bb, 32'h1234);
            check("s5_alu_ctl", alu_cb, 6);
        end
        tick();
        check("s5_rsp_valid", rvb, 1);
        check("s5_rsp_result", rresb, 0);
        check("s5_rsp_branch", rbrb, 1);
        check("s5_rsp_id", ridb, 0);
        tick();
        check("s5_idle", busyb, 0);

        // Async reset in the middle of an operation
        do_reset();
        rr = 1;
        a0 = 3; b0 = 4; c0 = 2; v0 = 1;
        tick();
        v0 = 0;
        check("s6_in_exec", busy, 1);
        rst_n = 0;
        #1;
        check("s6_rst_busy", busy, 0);
        check("s6_rst_alu_A", alu_a, 0);
        check("s6_rst_alu_B", alu_b, 0);
        check("s6_rst_alu_ctl", alu_c, 0);
        check("s6_rst_valid", rv, 0);
        tick();
        check("s6_rst_hold_valid", rv, 0);
        rst_n = 1;
        tick();
        check("s6_no_stale_rsp", rv, 0);
        a0 = 20; b0 = 20; c0 = 6; a1 = 1; b1 = 2; c1 = 1;
        v0 = 1; v1 = 1;
        #1;
        check("s6_ready0", r0, 1);
        check("s6_ready1", r1, 0);
        tick();
        v0 = 0;
        tick();
        check("s6_rsp_id", rid, 0);
        check("s6_rsp_result", rres, 0);
        check("s6_rsp_branch", rbr, 1);
        tick();
        tick();
        v1 = 0;
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational ALU in sail-core between two requesters: the main pipeline (port 0) and an auxiliary sequencer such as a multi-step mul/div or CSR unit (port 1).
- Arbitrates round-robin, registers the winning operands and ALU control word onto the ALU inputs, and waits a configurable settle time.
- Captures ALUOut and Branch_Enable, then returns them to the winner over a valid/ready response channel.
- Exactly one operation is in flight at a time.

Parameters:
- WIDTH, 32, operand/result width.
- CTL_W, 7, ALU control word width (matches ALUCtl).
- EXEC_CYCLES, 1, cycles the ALU inputs are held before the result is sampled (1..15).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_A  in  WIDTH  requester 0 operand A.
- req0_B  in  WIDTH  requester 0 operand B.
- req0_ctl  in  CTL_W  requester 0 ALU control word.
- req1_valid / req1_ready / req1_A / req1_B / req1_ctl: same as the req0 ports, for requester 1.
- alu_A  out  WIDTH  registered operand A to the ALU.
- alu_B  out  WIDTH  registered operand B to the ALU.
- alu_ctl  out  CTL_W  registered ALUctl to the ALU.
- alu_out  in  WIDTH  ALUOut from the ALU.
- alu_branch  in  1  Branch_Enable from the ALU.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes the result.
- rsp_id  out  1  requester that owns the result.
- rsp_result  out  WIDTH  captured ALUOut.
- rsp_branch  out  1  captured Branch_Enable.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, last_grant=1 (port 0 wins first). alu_A, alu_B, alu_ctl, rsp_result, rsp_branch, rsp_id, rsp_valid all 0; cnt=0.
- Handshake: transfer on reqN_valid && reqN_ready at a rising edge. reqN_ready is combinational, high only in IDLE and only for the granted port; never both ready in the same cycle.
- Grant in IDLE:
  - only one valid: grant it.
  - both valid: grant the port != last_grant.
  - none valid: no grant.
- Requesters must hold A/B/ctl stable while valid && !ready. The arbiter never samples operands except at the transfer edge.
- FSM IDLE:
  - on transfer: load alu_A/alu_B/alu_ctl from the winner; record rsp_id=winner, last_grant=winner; cnt=EXEC_CYCLES-1; go to EXEC.
- FSM EXEC:
  - alu_* held constant.
  - cnt!=0: decrement.
  - cnt==0: capture rsp_result=alu_out and rsp_branch=alu_branch; set rsp_valid=1; go to RESP.
- FSM RESP:
  - rsp_valid=1; rsp_* stable until rsp_ready.
  - rsp_ready=1: clear rsp_valid and go to IDLE at that edge. The next request is accepted no earlier than the following cycle.
- Latency: transfer at edge k, rsp_valid high from edge k+EXEC_CYCLES. Minimum issue interval is EXEC_CYCLES+2 cycles with rsp_ready tied high.
- alu_* keep their last values after completion; they are never driven to X.
- rsp_ready while rsp_valid=0 is ignored.
- Requests arriving in EXEC/RESP wait (ready=0). A request withdrawn before grant is legal and never executed.
- Reset mid-operation: immediate return to reset values; the in-flight op is discarded and no response is produced.
- EXEC_CYCLES=0 is illegal; flagged by a simulation-time check.

Test Plan:
Bench ALU model: ctl 0 → A&B; 1 → A|B; 2 → A+B; 6 → A−B; alu_branch=(A==B). EXEC_CYCLES=1 unless noted.
- Single op, port 0: A=0x0F, B=0x55, ctl=0, rsp_ready=1 → req0_ready in accept cycle; rsp_valid one cycle after the transfer edge; rsp_result=0x05, rsp_id=0, rsp_branch=0.
- Contention after reset: both valid; port 0 A=10000, B=111, ctl=2; port 1 A=10000, B=111, ctl=6 → port 0 granted first (result 10111, id 0); port 1 next (result 9889, id 1). Responses in grant order, never both readies together.
- Sustained contention: both valid for 6 ops → grants alternate 0,1,0,1,0,1. Port 1 held continuously valid alone → 3 back-to-back grants, each spaced 3 cycles apart.
- Backpressure: rsp_ready=0 for 5 cycles in RESP → rsp_valid/result/id stable, busy=1, both readies 0; release → IDLE next edge.
- EXEC_CYCLES=4: A=B=0x1234, ctl=6 → alu_* stable 4 cycles; rsp_result=0, rsp_branch=1, rsp_valid at transfer edge +4.
- Async reset asserted in EXEC → all outputs 0 immediately, no rsp_valid. After release, first grant goes to port 0 when both valid.
